// File: rtl/ifu_pkg.sv
// Shared constants and the prefetch-queue entry type for the instruction fetch unit.
package ifu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC          = 32'h0000_4180;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  // One prefetched word: instruction, its fetch address and the AdEL flag.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding prefetched entries; clr or flush empties it in one cycle.
module fetch_queue
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
)(
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         flush,
  input  logic                         push,
  input  fq_entry_t                    din,
  input  logic                         pop,
  output fq_entry_t                    dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fq_entry_t       mem_r [DEPTH];
  logic [PW-1:0]   rd_r;
  logic [PW-1:0]   wr_r;
  logic [CW-1:0]   count_r;
  logic            push_ok_s;
  logic            pop_ok_s;

  // Advance a ring pointer, wrapping at DEPTH (which need not be a power of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Accept a push when there is room or the head leaves in the same cycle.
  always_comb begin
    pop_ok_s  = pop & (count_r != '0);
    push_ok_s = push & ((count_r != CW'(DEPTH)) | pop_ok_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rd_r    <= '0;
      wr_r    <= '0;
      count_r <= '0;
    end else if (flush) begin
      rd_r    <= '0;
      wr_r    <= '0;
      count_r <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_r] <= din;
        wr_r        <= ptr_inc(wr_r);
      end
      if (pop_ok_s) begin
        rd_r <= ptr_inc(rd_r);
      end
      count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
    end
  end

  // Head entry and status flags straight from the registers.
  always_comb begin
    dout  = mem_r[rd_r];
    count = count_r;
    full  = (count_r == CW'(DEPTH));
    empty = (count_r == '0);
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: fetch PC, one-cycle-latency ROM interface, prefetch queue,
// branch/interrupt redirect and fetch address error (AdEL) reporting.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMEM_AW  = 12,
  parameter int          FQ_DEPTH = 2
)(
  input  logic               clk,
  input  logic               clr,
  input  logic               stall,
  input  logic               branch,
  input  logic               intreq,
  input  logic [31:0]        npcout,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               valid,
  output logic [31:0]        instr,
  output logic [31:0]        pc8,
  output logic               exc_adel
);

  localparam int          CW      = $clog2(FQ_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FQ_DEPTH);
  localparam logic [32:0] WIN_END = {1'b0, RESET_PC} + (33'd4 << IMEM_AW);

  logic [31:0]  fpc_r;
  logic [31:0]  tag_r;
  logic         inflight_r;
  logic         err_done_r;

  logic [CW-1:0] count_s;
  logic          full_s;
  logic          empty_s;
  logic [CW:0]   demand_s;
  logic          pop_s;
  logic          bad_s;
  logic          issue_s;
  logic          fetch_s;
  logic          err_push_s;
  logic          redirect_s;
  logic          push_s;
  logic          fq_pop_s;
  fq_entry_t     push_entry_s;
  fq_entry_t     head_s;

  // Fetch decision: address check, queue-space accounting (queued + in flight - leaving) and redirect.
  always_comb begin
    pop_s      = ~empty_s & ~stall;
    bad_s      = (fpc_r[1:0] != 2'b00) | (fpc_r < RESET_PC) | ({1'b0, fpc_r} >= WIN_END);
    demand_s   = {1'b0, count_s} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, pop_s};
    issue_s    = (demand_s < DEPTH_C);
    fetch_s    = issue_s & ~bad_s;
    // An error entry waits behind any response still in flight so program order is kept,
    // and is reported only once until the next redirect.
    err_push_s = issue_s & bad_s & ~inflight_r & ~err_done_r;
    redirect_s = intreq | (branch & ~stall);
    fq_pop_s   = pop_s & ~redirect_s;
    push_s     = ~redirect_s & (inflight_r | err_push_s) & (~full_s | fq_pop_s);
    if (inflight_r) begin
      push_entry_s = '{imem_rdata, tag_r, 1'b0};
    end else begin
      push_entry_s = '{NOP, fpc_r, 1'b1};
    end
  end

  // Fetch PC, in-flight tag and the one-shot error latch; a redirect squashes the in-flight read.
  always_ff @(posedge clk) begin
    if (clr) begin
      fpc_r      <= RESET_PC;
      tag_r      <= RESET_PC;
      inflight_r <= 1'b0;
      err_done_r <= 1'b0;
    end else if (redirect_s) begin
      fpc_r      <= npcout;
      inflight_r <= 1'b0;
      err_done_r <= 1'b0;
    end else begin
      inflight_r <= fetch_s;
      if (fetch_s) begin
        fpc_r <= fpc_r + 32'd4;
        tag_r <= fpc_r;
      end
      if (err_push_s) begin
        err_done_r <= 1'b1;
      end
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk   (clk),
    .clr   (clr),
    .flush (redirect_s),
    .push  (push_s),
    .din   (push_entry_s),
    .pop   (fq_pop_s),
    .dout  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // ROM interface and head-of-queue presentation to decode.
  always_comb begin
    imem_en   = fetch_s & ~clr;
    imem_addr = IMEM_AW'((fpc_r - RESET_PC) >> 2);
    valid     = ~empty_s;
    if (~empty_s) begin
      instr    = head_s.exc ? NOP : head_s.instr;
      pc8      = head_s.pc + 32'd8;
      exc_adel = head_s.exc;
    end else begin
      instr    = NOP;
      pc8      = fpc_r + 32'd8;
      exc_adel = 1'b0;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: expected instruction streams are queued on each
// redirect/reset and a negedge monitor compares every instruction decode consumes.
module tb_ifu_prefetch;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          IMEM_AW  = 12;
  localparam int          FQ_DEPTH = 2;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic        exc;
  } exp_t;

  logic               clk = 1'b0;
  logic               clr, stall, branch, intreq;
  logic [31:0]        npcout;
  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata = 32'h0;
  logic               valid;
  logic [31:0]        instr, pc8;
  logic               exc_adel;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  exp_t exp_q[$];
  logic        redir_pend = 1'b0;
  logic [31:0] redir_tgt  = 32'h0;

  ifu_prefetch #(.RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk(clk), .clr(clr), .stall(stall), .branch(branch), .intreq(intreq),
    .npcout(npcout), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .valid(valid), .instr(instr), .pc8(pc8), .exc_adel(exc_adel)
  );

  always #5 clk = ~clk;

  // ROM model: word i holds the value i, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'(imem_addr);
  end

  function automatic bit pc_bad(input logic [31:0] p);
    return (p % 4 != 0) || (longint'(p) < longint'(RESET_PC)) ||
           (longint'(p) >= longint'(RESET_PC) + 4 * (longint'(1) << IMEM_AW));
  endfunction

  // Expected stream from a start address: sequential words until the first bad address,
  // which yields one error entry and nothing after it.
  task automatic load_stream(input logic [31:0] start);
    logic [31:0] p;
    exp_t e;
    p = start;
    exp_q.delete();
    for (int n = 0; n < 300; n++) begin
      if (pc_bad(p)) begin
        e.instr = 32'h0; e.pc8 = p + 32'd8; e.exc = 1'b1;
        exp_q.push_back(e);
        break;
      end
      e.instr = (p - RESET_PC) / 4; e.pc8 = p + 32'd8; e.exc = 1'b0;
      exp_q.push_back(e);
      p = p + 32'd4;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Monitor: every instruction decode consumes must be the next one of the expected stream.
  always @(negedge clk) begin
    if (!clr && valid && !stall) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL extra_instr: got pc8=%h instr=%h exc=%b expected no entry", pc8, instr, exc_adel);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (instr === e.instr && pc8 === e.pc8 && exc_adel === e.exc) pass_cnt++;
        else $display("FAIL stream: got pc8=%h instr=%h exc=%b expected pc8=%h instr=%h exc=%b",
                      pc8, instr, exc_adel, e.pc8, e.instr, e.exc);
      end
    end
  end

  // One clock cycle: after the edge, reload the expectation if the last cycle redirected,
  // apply new inputs, then return at the falling edge for sampling.
  task automatic step(input logic c, input logic s, input logic b, input logic i,
                      input logic [31:0] npc);
    @(posedge clk);
    #1;
    if (redir_pend) load_stream(redir_tgt);
    clr = c; stall = s; branch = b; intreq = i; npcout = npc;
    redir_pend = c | i | (b & ~s);
    redir_tgt  = c ? RESET_PC : npc;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic s);
    for (int k = 0; k < n; k++) step(1'b0, s, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] npc;
    logic        s, b, i, cl;
    int          since;
    clr = 1'b1; stall = 1'b0; branch = 1'b0; intreq = 1'b0; npcout = 32'h0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_exc", 32'(exc_adel), 32'd0);
    chk("rst_imem_en", 32'(imem_en), 32'd0);
    chk("rst_pc8", pc8, 32'h3008);

    // First fetch latency and sequential stream
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("k_imem_en", 32'(imem_en), 32'd1);
    chk("k_imem_addr", 32'(imem_addr), 32'd0);
    chk("k_valid", 32'(valid), 32'd0);
    run(1, 1'b0);
    chk("k1_valid", 32'(valid), 32'd0);
    run(1, 1'b0);
    chk("k2_valid", 32'(valid), 32'd1);
    chk("k2_pc8", pc8, 32'h3008);
    chk("k2_instr", instr, 32'd0);
    run(1, 1'b0);
    chk("k3_pc8", pc8, 32'h300C);
    chk("k3_instr", instr, 32'd1);
    run(1, 1'b0);
    chk("k4_pc8", pc8, 32'h3010);
    chk("k4_instr", instr, 32'd2);

    // Stall five cycles: head frozen, queue fills, ROM idle
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("stall_pc8", pc8, exp_q[0].pc8);
      chk("stall_instr", instr, exp_q[0].instr);
    end
    chk("stall_imem_en", 32'(imem_en), 32'd0);
    run(4, 1'b0);

    // Branch redirect with no stall
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3100);
    run(1, 1'b0);
    chk("br_valid1", 32'(valid), 32'd0);
    run(1, 1'b0);
    chk("br_valid2", 32'(valid), 32'd0);
    run(1, 1'b0);
    chk("br_valid3", 32'(valid), 32'd1);
    chk("br_pc8", pc8, 32'h3108);
    chk("br_instr", instr, 32'h40);

    // Branch under stall is ignored; interrupt under stall with a full queue flushes
    run(3, 1'b0);
    run(3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_3500);
    chk("brst_valid", 32'(valid), 32'd1);
    chk("brst_pc8", pc8, exp_q[0].pc8);
    chk("brst_imem_en", 32'(imem_en), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, ifu_pkg::EXC_VEC);
    run(1, 1'b0);
    chk("int_valid1", 32'(valid), 32'd0);
    run(1, 1'b0);
    chk("int_valid2", 32'(valid), 32'd0);
    run(1, 1'b0);
    chk("int_valid3", 32'(valid), 32'd1);
    chk("int_pc8", pc8, 32'h4188);
    chk("int_exc", 32'(exc_adel), 32'd0);
    chk("int_instr", instr, 32'h460);

    // Misaligned branch target: a single error entry, then the unit parks
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3102);
    run(1, 1'b0);
    chk("adel_valid0", 32'(valid), 32'd0);
    chk("adel_imem_en0", 32'(imem_en), 32'd0);
    run(1, 1'b0);
    chk("adel_valid", 32'(valid), 32'd1);
    chk("adel_exc", 32'(exc_adel), 32'd1);
    chk("adel_instr", instr, 32'h0);
    chk("adel_pc8", pc8, 32'h310A);
    run(3, 1'b0);
    chk("adel_park_valid", 32'(valid), 32'd0);
    chk("adel_park_imem_en", 32'(imem_en), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, ifu_pkg::EXC_VEC);
    run(4, 1'b0);

    // clr with branch and intreq high and a full queue
    run(3, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_3500);
    chk("clr_imem_en", 32'(imem_en), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("clr_valid", 32'(valid), 32'd0);
    chk("clr_instr", instr, 32'h0);
    chk("clr_exc", 32'(exc_adel), 32'd0);
    chk("clr_pc8", pc8, 32'h3008);
    chk("clr_imem_addr", 32'(imem_addr), 32'd0);
    run(2, 1'b0);
    chk("clr_restart_pc8", pc8, 32'h3008);

    // Run off the top of the ROM window
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_6FF8);
    run(8, 1'b0);

    // Randomised traffic
    since = 0;
    for (int c = 0; c < 3000; c++) begin
      s = ($urandom_range(0, 99) < 30);
      b = 1'b0; i = 1'b0; cl = 1'b0;
      case ($urandom_range(0, 5))
        0:       npc = RESET_PC + 32'(4 * $urandom_range(0, 4095));
        1:       npc = 32'h0000_6FF0;
        2:       npc = ifu_pkg::EXC_VEC;
        3:       npc = RESET_PC + 32'($urandom_range(0, 16383));
        4:       npc = 32'h0000_2FFC;
        default: npc = 32'hFFFF_FFFC;
      endcase
      if (since > 180) i = 1'b1;
      else begin
        case ($urandom_range(0, 24))
          0:       b = 1'b1;
          1:       i = 1'b1;
          default: ;
        endcase
      end
      if ($urandom_range(0, 599) == 0) cl = 1'b1;
      step(cl, s, b, i, npc);
      since = (cl | i | (b & ~s)) ? 0 : since + 1;
    end
    run(6, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
Parametrised instruction fetch unit for the pipelined MIPS core.
- Holds the fetch PC and drives an external synchronous instruction ROM with a one-cycle read latency.
- Buffers fetched words in a small prefetch queue, so a decode stall never drops a ROM response.
- Handles sequential fetch, branch/jump redirect and interrupt redirect.
- Flags fetch address errors (AdEL) for the CP0 exception path.

Parameters:
RESET_PC, 32'h00003000, fetch address after clr; also the base of the ROM window
IMEM_AW, 12, ROM word-address width; window is RESET_PC .. RESET_PC+4*2^IMEM_AW-1
FQ_DEPTH, 2, prefetch queue entries (>=2)

Ports:
clk  in  1  core clock, rising edge
clr  in  1  synchronous active-high reset
stall  in  1  decode cannot accept an instruction this cycle
branch  in  1  taken branch/jump redirect request
intreq  in  1  interrupt/exception redirect request
npcout  in  32  redirect target for branch or intreq
imem_en  out  1  ROM read enable
imem_addr  out  IMEM_AW  ROM word address, (fpc-RESET_PC)[IMEM_AW+1:2]
imem_rdata  in  32  ROM data, valid the cycle after imem_en
valid  out  1  instr/pc8/exc_adel hold a real fetched entry
instr  out  32  head instruction; 32'h0 (nop) when !valid or exc_adel
pc8  out  32  head PC + 8 (link value); fpc+8 when !valid
exc_adel  out  1  head entry has a fetch address error

Behaviour:
Reset (clr=1 at a rising edge):
- fpc=RESET_PC; queue empty; in-flight flag cleared.
- valid=0, instr=0, exc_adel=0, imem_en=0.
- clr overrides every other input, including mid-redirect and a full queue.

Signals:
- pop = valid & !stall.
- bad = (fpc[1:0]!=0) | (fpc < RESET_PC) | (fpc >= RESET_PC + 4*2^IMEM_AW), unsigned compare.
- issue = (count + inflight - pop) < FQ_DEPTH. Widths: count of $clog2(FQ_DEPTH+1) bits; the sum is computed one bit wider.

Issue:
- issue & !bad: imem_en=1; inflight<=1 next cycle, tagged with fpc; fpc<=fpc+4 (wraps mod 2^32).
- issue & bad: no ROM access. Push an error entry {instr=0, pc=fpc, exc=1} directly. fpc holds, so the error is reported once and the unit waits for intreq.
- !issue: fpc holds, imem_en=0.

Response: when inflight=1, imem_rdata plus its tag is pushed at the next edge.

Output: the head is registered. Steady-state throughput is 1 instruction/cycle with FQ_DEPTH>=2.

Latency:
- First edge with clr=0 ends cycle k; the ROM is read in cycle k.
- Data is pushed at the end of cycle k+1; valid=1 in cycle k+2.
- Redirect to first valid is 2 cycles.

Redirect priority (evaluated each edge):
- intreq: flush the queue, squash in-flight, fpc<=npcout. Applies regardless of stall.
- else branch & !stall: same flush/squash, fpc<=npcout.
- else branch & stall: ignored. Decode re-presents branch when the stall releases.
- Same-cycle pop is discarded on a flush; the head instruction was consumed by decode.

Squash: a response arriving in the cycle after a flush is dropped, never pushed.

Queue boundaries:
- Full queue with stall: no issue, fpc holds, contents preserved.
- Push and pop in the same cycle: count unchanged.
- Empty queue: valid=0.

npcout alignment: npcout with [1:0]!=0 is accepted into fpc and then raises exc_adel via bad.

Decomposition:
ifu_pkg holds:
- RESET_PC_DEFAULT and EXC_VEC (32'h00004180).
- the NOP constant.
- a queue-entry struct {instr[31:0], pc[31:0], exc}.

Sub-module fetch_queue: synchronous FIFO with push, pop, flush, count, full, empty, parametrised on FQ_DEPTH. Its clr and flush both empty it in one cycle.

Test Plan:
- Reset then free-run, stall=0, ROM word i=i: valid rises 2 cycles after clr falls; pc8 = 0x3008, 0x300C, ...; instr = 0, 1, 2 on consecutive cycles.
- stall=1 for 5 cycles mid-stream: instr/pc8 frozen; count reaches FQ_DEPTH; imem_en=0. On release, consecutive PCs resume with none lost or duplicated.
- branch=1, npcout=0x3100, stall=0: next two cycles valid=0 (old in-flight squashed); then pc8=0x3108.
- branch=1 with stall=1: fpc unchanged, queue kept. Assert intreq=1, npcout=0x4180, with stall=1 and a full queue: flush occurs; first valid pc8=0x4188 with exc_adel=0 (requires IMEM_AW large enough; else exc_adel=1).
- npcout=0x3102 via branch: one entry valid=1, exc_adel=1, instr=0, pc8=0x310A; imem_en stays 0 until intreq.
- clr pulse while branch and intreq are high and the queue is full: all outputs return to reset values; fetch restarts at 0x3000.
